// File: rtl/avg_share_ctrl.sv
// Purpose: shares one 3-tap weighted-average MAC between N_CH sample streams, with round-robin accept.
// Latency: a sample accepted at cycle T gives out_valid at T+4; at most one result every 5 cycles.
// Backpressure: a result is held stable until out_ready; no new sample is granted until it is taken.
//
// Ports:
//   clk, rst              single clock; synchronous active-high reset
//   in_valid/in_data      per-channel sample requests (ch k at [k*DATA_W +: DATA_W])
//   in_ready              one-hot grant, combinational, only ever asserted in IDLE
//   out_valid/out_ready   result handshake; out_data is the sum, out_ch is the source channel
//   cfg_we/cfg_idx/cfg_coef  coefficient write, honoured only in IDLE, index 3 ignored
//   busy                  high whenever the sequencer is not IDLE
module avg_share_ctrl #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int CH_W   = 2,
    parameter int ACC_W  = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_idx,
    input  logic [COEF_W-1:0]        cfg_coef,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_OUT
    } state_t;

    state_t              state_q;

    // hist_q[ch][0] is the most recent sample of that channel, [1] the one before.
    logic [DATA_W-1:0]   hist_q [N_CH][2];
    logic [COEF_W-1:0]   coef_q [3];
    logic [DATA_W-1:0]   tap_q  [3];
    logic [ACC_W-1:0]    acc_q;
    logic [CH_W-1:0]     tag_q;
    logic [CH_W-1:0]     last_q;

    logic                out_valid_q;
    logic [ACC_W-1:0]    out_data_q;
    logic [CH_W-1:0]     out_ch_q;

    // Arbitration results
    logic                found;
    logic [CH_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_sample;
    logic [DATA_W-1:0]   grant_h0;
    logic [DATA_W-1:0]   grant_h1;

    // MAC datapath
    logic [COEF_W-1:0]   coef_sel;
    logic [DATA_W-1:0]   tap_sel;
    logic [ACC_W-1:0]    acc_d;

    // Round-robin: walk last+1, last+2, ... (mod N_CH) and take the first requester.
    // The nested loop keeps every index a constant, so no wide dynamic selects are needed.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            for (int j = 0; j < N_CH; j++) begin
                if (!found && in_valid[j] && (j == ((int'(last_q) + i) % N_CH))) begin
                    found     = 1'b1;
                    grant_idx = CH_W'(j);
                end
            end
        end
    end

    // Fetch the granted channel's sample and history.
    always_comb begin
        grant_sample = '0;
        grant_h0     = '0;
        grant_h1     = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (grant_idx == CH_W'(j)) begin
                grant_sample = in_data[j*DATA_W +: DATA_W];
                grant_h0     = hist_q[j][0];
                grant_h1     = hist_q[j][1];
            end
        end
    end

    // Grant is only visible in IDLE and is suppressed while reset is asserted.
    always_comb begin
        in_ready = '0;
        for (int j = 0; j < N_CH; j++) begin
            in_ready[j] = (state_q == S_IDLE) && !rst && found && (grant_idx == CH_W'(j));
        end
    end

    // One coefficient/tap pair per MAC cycle.
    always_comb begin
        coef_sel = coef_q[0];
        tap_sel  = tap_q[0];
        case (state_q)
            S_MAC1: begin
                coef_sel = coef_q[1];
                tap_sel  = tap_q[1];
            end
            S_MAC2: begin
                coef_sel = coef_q[2];
                tap_sel  = tap_q[2];
            end
            default: ;
        endcase
    end

    // ACC_W holds 3 full-width products, so widening both operands first never wraps.
    assign acc_d = acc_q + (ACC_W'(coef_sel) * ACC_W'(tap_sel));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            acc_q       <= '0;
            tag_q       <= '0;
            last_q      <= CH_W'(N_CH - 1);
            for (int j = 0; j < N_CH; j++) begin
                hist_q[j][0] <= '0;
                hist_q[j][1] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                coef_q[k] <= COEF_W'(2);
                tap_q[k]  <= '0;
            end
        end else begin
            // A write in the accept cycle still lands before MAC0 reads coef_q.
            if ((state_q == S_IDLE) && cfg_we) begin
                case (cfg_idx)
                    2'd0:    coef_q[0] <= cfg_coef;
                    2'd1:    coef_q[1] <= cfg_coef;
                    2'd2:    coef_q[2] <= cfg_coef;
                    default: ;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        tap_q[0] <= grant_sample;
                        tap_q[1] <= grant_h0;
                        tap_q[2] <= grant_h1;
                        for (int j = 0; j < N_CH; j++) begin
                            if (grant_idx == CH_W'(j)) begin
                                hist_q[j][1] <= hist_q[j][0];
                                hist_q[j][0] <= grant_sample;
                            end
                        end
                        acc_q   <= '0;
                        tag_q   <= grant_idx;
                        last_q  <= grant_idx;
                        state_q <= S_MAC0;
                    end
                end
                S_MAC0: begin
                    acc_q   <= acc_d;
                    state_q <= S_MAC1;
                end
                S_MAC1: begin
                    acc_q   <= acc_d;
                    state_q <= S_MAC2;
                end
                S_MAC2: begin
                    acc_q       <= acc_d;
                    out_data_q  <= acc_d;
                    out_ch_q    <= tag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_avg_share_ctrl.sv
module tb_avg_share_ctrl;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int CH_W   = 2;
    localparam int ACC_W  = 18;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   cfg_we;
    logic [1:0]             cfg_idx;
    logic [COEF_W-1:0]      cfg_coef;
    logic                   busy;

    avg_share_ctrl #(
        .N_CH(N_CH), .DATA_W(DATA_W), .COEF_W(COEF_W), .CH_W(CH_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_coef(cfg_coef), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [ACC_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: grant shape, accept-to-valid latency, and scoreboard comparison.
    always @(negedge clk) begin
        check("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
        if (rst) begin
            acc_cyc.delete();
            prev_ov = 1'b0;
        end else begin
            if (|(in_valid & in_ready)) acc_cyc.push_back(cyc);
            if (out_valid && !prev_ov) begin
                if (acc_cyc.size() == 0) begin
                    check("accept_before_out", 64'(acc_cyc.size()), 64'd1);
                end else begin
                    int t;
                    t = acc_cyc.pop_front();
                    check("latency", 64'(cyc - t), 64'd4);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_ch", 64'(out_ch), 64'(e.ch));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input int ch, input int val, input int exp_v);
        logic [DATA_W-1:0] v;
        bit got;
        exp_t e;
        v      = DATA_W'(val);
        e.ch   = CH_W'(ch);
        e.data = ACC_W'(exp_v);
        sb.push_back(e);
        @(posedge clk); #1;
        in_data[ch*DATA_W +: DATA_W] = v;
        in_valid[ch] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready[ch]) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && !out_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic cfg(input int idx, input int val);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_coef = COEF_W'(val);
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_coef  = '0;

        // Reset state, with requests present to show no grant under reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: ch0 samples with default coefficients of 2.
        send(0, 10, 20);
        send(0, 20, 60);
        send(0, 30, 120);
        wait_idle();

        // 2: all channels requesting, grants rotate from ch0.
        do_reset();
        in_data = {8'd4, 8'd3, 8'd2, 8'd1};
        begin
            exp_t e;
            int   order [6] = '{0, 1, 2, 3, 0, 1};
            int   vals  [6] = '{2, 4, 6, 8, 4, 8};
            for (int k = 0; k < 6; k++) begin
                e.ch   = CH_W'(order[k]);
                e.data = ACC_W'(vals[k]);
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        in_valid = 4'b1111;
        begin
            int n = 0;
            for (int k = 0; k < 200 && n < 6; k++) begin
                @(negedge clk);
                if (|in_ready) n++;
            end
            check("grant_count", 64'(n), 64'd6);
        end
        @(posedge clk); #1;
        in_valid = '0;
        wait_idle();

        // ch2 alone (history 3,0), then all request: ch3 then ch0 come next.
        send(2, 5, 16);
        wait_idle();
        begin
            exp_t e;
            e.ch = 2'd3; e.data = 18'd16; sb.push_back(e);
            e.ch = 2'd0; e.data = 18'd6;  sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 4'b1111;
        begin
            int n = 0;
            for (int k = 0; k < 100 && n < 2; k++) begin
                @(negedge clk);
                if (|in_ready) n++;
            end
            check("grant_count_rr", 64'(n), 64'd2);
        end
        @(posedge clk); #1;
        in_valid = '0;
        wait_idle();

        // 3: output held under backpressure (ch1 history 2,2 -> 2*(10+2+2)).
        out_ready = 1'b0;
        send(1, 10, 28);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("bp_valid_seen", 64'(seen), 64'd1);
        end
        in_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'd28);
            check("bp_out_ch", 64'(out_ch), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
        end
        in_valid[0] = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // 4: programmed coefficients, then full-scale without wrap.
        do_reset();
        wait_idle();
        cfg(0, 1);
        cfg(1, 0);
        cfg(2, 255);
        send(1, 255, 255);
        send(1, 255, 255);
        send(1, 255, 65280);
        wait_idle();
        cfg(0, 255);
        cfg(1, 255);
        send(1, 255, 195075);
        wait_idle();

        // 5: writes while busy and to index 3 are dropped.
        send(2, 10, 2550);
        @(posedge clk); #1;
        check("busy_in_mac1", 64'(busy), 64'd1);
        cfg(0, 1);
        wait_idle();
        cfg(3, 9);
        send(2, 1, 2805);
        wait_idle();

        // 6: reset in MAC1 discards the result and restores defaults.
        send(3, 50, 12750);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 7, 14);
        wait_idle();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
